// File: rtl/memory_stage.sv
// Y-86 pipeline memory stage: data-memory access with optional wait states,
// forwarding outputs (m_valM, m_stat) and the W pipeline register.
module memory_stage #(
  parameter int unsigned DMEM_BYTES = 1024,
  parameter int unsigned MEM_WAIT   = 0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [144:0] M,
  input  logic         W_stall,
  input  logic         W_bubble,
  output logic [63:0]  m_valM,
  output logic         m_stat,
  output logic         m_busy,
  output logic [140:0] W
);

  localparam int AW = $clog2(DMEM_BYTES);
  localparam int CW = (MEM_WAIT > 0) ? $clog2(MEM_WAIT + 1) : 1;
  localparam bit HAS_WAIT = (MEM_WAIT != 0);
  localparam logic [CW-1:0] WAIT_INIT = HAS_WAIT ? CW'(MEM_WAIT - 1) : '0;
  localparam logic [63:0] ADDR_MAX = 64'(DMEM_BYTES - 8);

  localparam logic [3:0] I_HALT   = 4'd0;
  localparam logic [3:0] I_RMMOVQ = 4'd4;
  localparam logic [3:0] I_MRMOVQ = 4'd5;
  localparam logic [3:0] I_CALL   = 4'd8;
  localparam logic [3:0] I_RET    = 4'd9;
  localparam logic [3:0] I_PUSHQ  = 4'd10;
  localparam logic [3:0] I_POPQ   = 4'd11;

  localparam logic [140:0] W_BUBBLE = {1'b0, 4'h1, 64'd0, 64'd0, 4'hf, 4'hf};

  typedef enum logic {S_IDLE, S_WAIT} state_e;

  logic [3:0]    icode;
  logic [63:0]   val_e, val_a;
  logic [3:0]    dst_e, dst_m;
  logic          is_rd, is_wr, access, adr_err, complete, mem_we;
  logic [63:0]   addr, rd_word;
  logic [AW-1:0] base;
  state_e        state;
  logic [CW-1:0] cnt;
  logic [7:0]    mem [DMEM_BYTES];
  logic          unused_cnd;

  assign icode      = M[143:140];
  assign val_e      = M[135:72];
  assign val_a      = M[71:8];
  assign dst_e      = M[7:4];
  assign dst_m      = M[3:0];
  assign unused_cnd = ^M[139:136];

  // NOTE: every variable written in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    is_rd = 1'b0;
    is_wr = 1'b0;
    addr  = val_e;
    case (icode)
      I_RMMOVQ, I_CALL, I_PUSHQ: is_wr = 1'b1;
      I_MRMOVQ:                  is_rd = 1'b1;
      I_RET, I_POPQ: begin
        is_rd = 1'b1;
        addr  = val_a;
      end
      default: ;
    endcase
  end

  assign access  = is_rd | is_wr;
  assign adr_err = access && (addr > ADDR_MAX);
  assign m_stat  = M[144] | adr_err | (icode == I_HALT);
  assign base    = addr[AW-1:0];

  // Little-endian word assembly straight from the byte array.
  always_comb begin
    rd_word = '0;
    for (int k = 0; k < 8; k++)
      rd_word[8*k +: 8] = mem[base + AW'(k)];
  end

  assign m_valM = (is_rd && !adr_err) ? rd_word : 64'd0;

  always_comb begin
    if (state == S_IDLE)
      m_busy = access && HAS_WAIT && !adr_err;
    else
      m_busy = (cnt != '0);
  end

  // A write commits only on the edge that finishes the access, and never once the machine halted.
  assign complete = access && !m_busy;
  assign mem_we   = complete && is_wr && !m_stat && !W[140] && !reset;

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (access && HAS_WAIT && !adr_err) begin
            state <= S_WAIT;
            cnt   <= WAIT_INIT;
          end
        end
        S_WAIT: begin
          if (cnt == '0) state <= S_IDLE;
          else           cnt   <= cnt - CW'(1);
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // NOTE: the data memory has no reset; its contents survive reset and are loaded externally.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int k = 0; k < 8; k++)
        mem[base + AW'(k)] <= val_a[8*k +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (reset)
      W <= W_BUBBLE;
    else if (W_stall)
      W <= W;
    else if (m_busy || W_bubble)
      W <= W_BUBBLE;
    else
      W <= {m_stat, icode, val_e, m_valM, dst_e, dst_m};
  end

endmodule

// File: tb/tb_memory_stage.sv
// Randomized self-checking bench for memory_stage: one instance without and one
// with wait states, both compared against a byte-array reference model.
module tb_memory_stage;

  localparam int DMEM = 1024;
  localparam logic [140:0] BUB   = {1'b0, 4'h1, 64'd0, 64'd0, 4'hf, 4'hf};
  localparam logic [144:0] NOP_M = {1'b0, 4'h1, 4'h0, 64'd0, 64'd0, 4'hf, 4'hf};

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [144:0] m_in   [2];
  logic         w_stall[2];
  logic         w_bub  [2];
  logic [63:0]  valm_o [2];
  logic         mstat  [2];
  logic         busy   [2];
  logic [140:0] w_out  [2];

  logic [7:0]   ref_mem [2][DMEM];
  logic [140:0] ref_w   [2];
  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  memory_stage #(.DMEM_BYTES(DMEM), .MEM_WAIT(0)) u0 (
    .clk(clk), .reset(reset), .M(m_in[0]), .W_stall(w_stall[0]), .W_bubble(w_bub[0]),
    .m_valM(valm_o[0]), .m_stat(mstat[0]), .m_busy(busy[0]), .W(w_out[0])
  );

  memory_stage #(.DMEM_BYTES(DMEM), .MEM_WAIT(2)) u2 (
    .clk(clk), .reset(reset), .M(m_in[1]), .W_stall(w_stall[1]), .W_bubble(w_bub[1]),
    .m_valM(valm_o[1]), .m_stat(mstat[1]), .m_busy(busy[1]), .W(w_out[1])
  );

  function automatic int wait_of(input int d);
    return (d == 0) ? 0 : 2;
  endfunction

  task automatic check(input string tag, input logic [140:0] got, input logic [140:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Presents one instruction to instance d (the other instance is stalled on a nop)
  // and follows it until its access has completed. Starts and ends at a negedge.
  task automatic op(input int d, input bit st, input logic [3:0] ic,
                    input logic [63:0] ve, input logic [63:0] va,
                    input logic [3:0] de, input logic [3:0] dm,
                    input bit stall, input bit bub);
    logic [63:0] addr, valm;
    bit rd, wr, err, mst;
    int nb;
    int o = 1 - d;
    m_in[d]    = {st, ic, 4'($urandom_range(0, 15)), ve, va, de, dm};
    w_stall[d] = stall;
    w_bub[d]   = bub;
    m_in[o]    = NOP_M;
    w_stall[o] = 1'b1;
    w_bub[o]   = 1'b0;
    rd   = (ic == 4'd5) || (ic == 4'd9) || (ic == 4'd11);
    wr   = (ic == 4'd4) || (ic == 4'd8) || (ic == 4'd10);
    addr = (ic == 4'd9 || ic == 4'd11) ? va : ve;
    err  = (rd || wr) && (addr > 64'(DMEM - 8));
    mst  = st || err || (ic == 4'd0);
    valm = '0;
    if (rd && !err)
      for (int b = 0; b < 8; b++) valm[8*b +: 8] = ref_mem[d][int'(addr) + b];
    nb = ((rd || wr) && !err) ? wait_of(d) : 0;
    for (int c = 0; c <= nb; c++) begin
      #1;
      check($sformatf("d%0d busy ic%0d c%0d", d, ic, c), 141'(busy[d]), 141'(c < nb));
      check($sformatf("d%0d m_stat ic%0d", d, ic), 141'(mstat[d]), 141'(mst));
      check($sformatf("d%0d m_valM ic%0d a%0h", d, ic, addr), 141'(valm_o[d]), 141'(valm));
      @(posedge clk);
      if (c == nb && wr && !mst && !ref_w[d][140])
        for (int b = 0; b < 8; b++) ref_mem[d][int'(addr) + b] = va[8*b +: 8];
      if (!stall)
        ref_w[d] = (c < nb || bub) ? BUB : {mst, ic, ve, valm, de, dm};
      #1;
      check($sformatf("d%0d W ic%0d c%0d", d, ic, c), w_out[d], ref_w[d]);
      @(negedge clk);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    for (int d = 0; d < 2; d++) begin
      m_in[d] = NOP_M; w_stall[d] = 1'b0; w_bub[d] = 1'b0;
    end
    @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      ref_w[d] = BUB;
      check($sformatf("d%0d reset W", d), w_out[d], BUB);
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) check($sformatf("d%0d reset busy", d), 141'(busy[d]), 141'(0));
  endtask

  initial begin
    logic [3:0]  ic;
    logic [63:0] addr, data, ve, va;
    int r;
    for (int d = 0; d < 2; d++) for (int a = 0; a < DMEM; a++) ref_mem[d][a] = '0;
    do_reset();
    @(negedge clk);

    // Known contents for the working region and the top word.
    for (int d = 0; d < 2; d++) begin
      for (int a = 0; a < 'h200; a += 8)
        op(d, 0, 4'd4, 64'(a), {$urandom, $urandom}, 4'hf, 4'hf, 0, 0);
      op(d, 0, 4'd4, 64'(DMEM - 8), {$urandom, $urandom}, 4'hf, 4'hf, 0, 0);
    end

    // Store then load round trip, single-cycle memory.
    op(0, 0, 4'd4, 64'h10, 64'h1122334455667788, 4'hf, 4'hf, 0, 0);
    op(0, 0, 4'd5, 64'h10, 64'h0, 4'hf, 4'h3, 0, 0);
    check("t1 W valM", 141'(w_out[0][71:8]), 141'(64'h1122334455667788));
    check("t1 W stat", 141'(w_out[0][140]), 141'(0));
    check("t1 byte10", 141'(u0.mem[16]), 141'(8'h88));

    // Load with two wait states.
    op(1, 0, 4'd5, 64'h20, 64'h0, 4'hf, 4'h2, 0, 0);
    check("t2 W icode", 141'(w_out[1][139:136]), 141'(4'h5));

    // Address just past the last legal word.
    for (int d = 0; d < 2; d++) begin
      op(d, 0, 4'd4, 64'(DMEM - 7), 64'hdeadbeefcafef00d, 4'hf, 4'hf, 0, 0);
      check($sformatf("d%0d t3 W stat", d), 141'(w_out[d][140]), 141'(1));
      op(d, 0, 4'd5, 64'(DMEM - 8), 64'h0, 4'hf, 4'h1, 0, 0);
      op(d, 0, 4'd11, 64'h0, 64'(DMEM - 7), 4'h4, 4'h1, 0, 0);
    end

    // Halt reaches W, following push must not write.
    op(0, 0, 4'd0, 64'h0, 64'h0, 4'hf, 4'hf, 0, 0);
    op(0, 0, 4'd10, 64'h40, 64'h5555aaaa5555aaaa, 4'h4, 4'hf, 0, 0);
    op(0, 0, 4'd5, 64'h40, 64'h0, 4'hf, 4'h1, 0, 0);

    // Reset in the middle of a waited push.
    m_in[1] = {1'b0, 4'd10, 4'h0, 64'h48, 64'h0badc0de0badc0de, 4'h4, 4'hf};
    w_stall[1] = 1'b0; w_bub[1] = 1'b0;
    m_in[0] = NOP_M; w_stall[0] = 1'b1; w_bub[0] = 1'b0;
    #1;
    check("t5 busy before reset", 141'(busy[1]), 141'(1));
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    ref_w[0] = BUB; ref_w[1] = BUB;
    check("t5 W after reset", w_out[1], BUB);
    @(negedge clk);
    reset = 1'b0;
    m_in[1] = NOP_M;
    #1;
    check("t5 busy after reset", 141'(busy[1]), 141'(0));
    @(negedge clk);
    op(1, 0, 4'd5, 64'h48, 64'h0, 4'hf, 4'h1, 0, 0);

    // Stall and bubble on a non-memory instruction.
    op(0, 0, 4'd6, 64'h77, 64'h0, 4'h2, 4'hf, 1, 0);
    op(0, 0, 4'd6, 64'h78, 64'h0, 4'h2, 4'hf, 0, 1);
    op(0, 0, 4'd6, 64'h79, 64'h0, 4'h2, 4'hf, 1, 1);

    // Random instruction mix over both instances.
    repeat (400) begin
      r = int'($urandom_range(0, 11));
      ic = 4'(r);
      r = int'($urandom_range(0, 9));
      if (r == 0)      addr = 64'(DMEM - 8 + int'($urandom_range(1, 16)));
      else if (r == 1) addr = {1'b1, 31'($urandom), $urandom};
      else             addr = 64'($urandom_range(0, 'h1f8));
      data = {$urandom, $urandom};
      if (ic == 4'd9 || ic == 4'd11) begin va = addr; ve = data; end
      else begin ve = addr; va = data; end
      op(int'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0), ic, ve, va,
         4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
         ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
